// File: rtl/cache_pkg.sv
// Shared definitions for the core-to-cache adapter: request encodings, FSM states, abort data.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    localparam logic [1:0]  REQ_READ     = 2'b00;
    localparam logic [1:0]  REQ_WRITE    = 2'b01;
    localparam logic [1:0]  REQ_FLUSH    = 2'b10;

    // Load data returned to the core when a transaction is aborted by timeout
    localparam logic [31:0] DEADBEAT_DAT = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_MERGE    = 3'd3,
        ST_RESP     = 3'd4,
        ST_FL_ISSUE = 3'd5,
        ST_FL_WAIT  = 3'd6
    } state_t;

endpackage

// File: rtl/cache_core_adapter_if.sv
// Single-word cache request bus: strobe-based request, one-cycle completion pulse with read data.
// Latency: set by the cache; req_done may arrive any cycle after req_do.
// Backpressure: none on the bus itself; the initiator keeps one request outstanding.
interface cache_core_adapter_if;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_type;
    logic        req_do;
    logic [31:0] O_data;
    logic        req_done;

    modport master (
        output req_addr, req_data, req_type, req_do,
        input  O_data, req_done
    );

    modport slave (
        input  req_addr, req_data, req_type, req_do,
        output O_data, req_done
    );
endinterface

// File: rtl/cache_be_merge.sv
// Byte-enable merge: each byte comes from new_i where be_i is set, otherwise from old_i.
// Latency: combinational.
// Backpressure: none.
module cache_be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    // Per-byte select between the stored word and the store data
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[i*8 +: 8] = new_i[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/cache_core_adapter.sv
// Core OBI-style data port to single-word cache requests; partial stores via read-modify-write; flush side request.
// Latency: load/full store = gnt + 1 + cache latency + 1; partial store adds a merge cycle and a second access.
// Backpressure: one transaction in flight; core_gnt only in IDLE with no flush requested or pending.
module cache_core_adapter
    import cache_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_req,
    output logic                 core_gnt,
    input  logic                 core_we,
    input  logic [3:0]           core_be,
    input  logic [31:0]          core_addr,
    input  logic [31:0]          core_wdata,
    output logic                 core_rvalid,
    output logic [31:0]          core_rdata,
    output logic                 core_err,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 err_sticky,
    cache_core_adapter_if.master cache
);

    state_t           state_q, state_d;
    logic [31:0]      req_addr_q, req_data_q, wdata_q, old_q, rdata_q;
    logic [1:0]       req_type_q;
    logic [3:0]       be_q;
    logic             we_q, phase_q, flush_pend_q, err_sticky_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      merged_w;
    logic             grant_w, flush_want_w, partial_w, cnt_hit_w;
    logic             wait_tmo_w, fl_tmo_w, fl_end_w;

    // A requested flush takes priority over the core, so the grant is held off
    // in the same cycle rather than granting a request that would be dropped.
    assign flush_want_w = flush_pend_q || flush_req;
    assign grant_w      = !reset && (state_q == ST_IDLE) && core_req && !flush_want_w;
    assign partial_w    = (be_q != 4'hF);

    // The count equals the number of completed cycles without req_done, so the
    // abort fires in the TIMEOUT-th waiting cycle; a req_done in that cycle wins.
    assign cnt_hit_w  = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign wait_tmo_w = (state_q == ST_WAIT)    && !cache.req_done && cnt_hit_w;
    assign fl_tmo_w   = (state_q == ST_FL_WAIT) && !cache.req_done && cnt_hit_w;
    assign fl_end_w   = (state_q == ST_FL_WAIT) && (cache.req_done || cnt_hit_w);

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_want_w) begin
                    state_d = ST_FL_ISSUE;
                end else if (grant_w) begin
                    state_d = (core_be == 4'h0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:    state_d = ST_WAIT;
            ST_WAIT: begin
                if (cache.req_done) begin
                    state_d = (we_q && partial_w && !phase_q) ? ST_MERGE : ST_RESP;
                end else if (wait_tmo_w) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MERGE:    state_d = ST_ISSUE;
            ST_RESP:     state_d = ST_IDLE;
            ST_FL_ISSUE: state_d = ST_FL_WAIT;
            ST_FL_WAIT:  state_d = fl_end_w ? ST_IDLE : ST_FL_WAIT;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Control state, pending flush, sticky error and the wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            err_sticky_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (fl_end_w) begin
                flush_pend_q <= 1'b0;
            end else if (flush_req && (state_q != ST_IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            if (wait_tmo_w || fl_tmo_w) begin
                err_sticky_q <= 1'b1;
            end
            if ((state_q == ST_WAIT) || (state_q == ST_FL_WAIT)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Transaction capture, cache request registers and returned data
    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr_q <= '0;
            req_data_q <= '0;
            req_type_q <= REQ_READ;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            phase_q    <= 1'b0;
            old_q      <= '0;
            rdata_q    <= '0;
        end else begin
            if (grant_w) begin
                we_q    <= core_we;
                be_q    <= core_be;
                wdata_q <= core_wdata;
                phase_q <= 1'b0;
                // A be=0000 access never reaches the cache, so the bus keeps its last request
                if (core_be != 4'h0) begin
                    req_addr_q <= {core_addr[31:2], 2'b00};
                    req_data_q <= core_wdata;
                    req_type_q <= (core_we && (core_be == 4'hF)) ? REQ_WRITE : REQ_READ;
                end
            end else if ((state_q == ST_IDLE) && flush_want_w) begin
                req_addr_q <= '0;
                req_data_q <= '0;
                req_type_q <= REQ_FLUSH;
            end

            if ((state_q == ST_WAIT) && cache.req_done) begin
                old_q <= cache.O_data;
                if (!we_q) begin
                    rdata_q <= cache.O_data;
                end
            end else if (wait_tmo_w && !we_q) begin
                rdata_q <= DEADBEAT_DAT;
            end

            // Second phase of a partial store writes the merged word back
            if (state_q == ST_MERGE) begin
                req_data_q <= merged_w;
                req_type_q <= REQ_WRITE;
                phase_q    <= 1'b1;
            end
        end
    end

    cache_be_merge u_merge (
        .old_i    (old_q),
        .new_i    (wdata_q),
        .be_i     (be_q),
        .merged_o (merged_w)
    );

    assign core_gnt    = grant_w;
    assign core_rvalid = !reset && ((state_q == ST_RESP) || wait_tmo_w);
    assign core_err    = !reset && wait_tmo_w;
    assign core_rdata  = reset ? '0 : (wait_tmo_w ? DEADBEAT_DAT : rdata_q);
    assign flush_done  = !reset && fl_end_w;
    assign err_sticky  = err_sticky_q;

    assign cache.req_do   = !reset && ((state_q == ST_ISSUE) || (state_q == ST_FL_ISSUE));
    assign cache.req_addr = req_addr_q;
    assign cache.req_data = req_data_q;
    assign cache.req_type = req_type_q;

endmodule

// File: tb/tb_cache_core_adapter.sv
// Bench for cache_core_adapter: directed scenarios plus randomized traffic against a word-level memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_core_adapter;
    import cache_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_gnt, core_rvalid, core_err;
    logic [3:0]  core_be;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        flush_req, flush_done, err_sticky;

    cache_core_adapter_if cif();

    cache_core_adapter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_gnt   (core_gnt),
        .core_we    (core_we),
        .core_be    (core_be),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .core_err   (core_err),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .err_sticky (err_sticky),
        .cache      (cif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } req_t;

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;
    logic [31:0] mem     [0:255];   // cache contents (environment)
    logic [31:0] ref_mem [0:255];   // reference view of memory
    logic [31:0] ref_rdata;
    int          lat;               // cycles from req_do to req_done; -1 never answers
    bit          pend = 0;
    int          due;
    logic [1:0]  p_t;
    logic [31:0] p_a, p_d;
    req_t        reqs[$];
    int          n_rv = 0, rv_cyc = 0, n_fd = 0, fd_cyc = 0, n_gnt = 0, gnt_cyc = 0;
    logic [31:0] rv_dat;
    logic        rv_err;

    // One clock: observe outputs mid-cycle, then act as the cache for the next cycle
    task automatic tick();
        req_t r;
        @(negedge clk);
        if (cif.req_do === 1'b1) begin
            r.t = cif.req_type; r.a = cif.req_addr; r.d = cif.req_data; r.c = cyc;
            reqs.push_back(r);
            if (lat >= 0) begin
                pend = 1; due = cyc + lat; p_t = r.t; p_a = r.a; p_d = r.d;
            end
        end
        if (core_rvalid === 1'b1) begin n_rv++; rv_cyc = cyc; rv_dat = core_rdata; rv_err = core_err; end
        if (flush_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
        if (core_gnt === 1'b1) begin n_gnt++; gnt_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        cif.req_done = 1'b0;
        cif.O_data   = $urandom;
        if (pend && cyc == due) begin
            pend = 0;
            cif.req_done = 1'b1;
            if (p_t == REQ_READ) cif.O_data = mem[p_a[9:2]];
            else if (p_t == REQ_WRITE) mem[p_a[9:2]] = p_d;
        end
    endtask

    // Present one core access, drop the request after grant, wait for the response
    task automatic core_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wd, output bit ok);
        int g0, v0;
        g0 = n_gnt; v0 = n_rv;
        core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = wd;
        for (int i = 0; i < 50 && n_gnt == g0; i++) tick();
        core_req = 1'b0; core_we = $urandom; core_be = $urandom; core_addr = $urandom; core_wdata = $urandom;
        for (int i = 0; i < 200 && n_rv == v0; i++) tick();
        ok = (n_gnt == g0 + 1) && (n_rv == v0 + 1);
    endtask

    function automatic logic [103:0] outs();
        return {core_gnt, core_rvalid, core_err, flush_done, err_sticky, cif.req_do, cif.req_type,
                core_rdata, cif.req_addr, cif.req_data};
    endfunction

    task automatic test_reset();
        reset = 1'b1; core_req = 1'b1; core_be = 4'hF;
        tick(); tick();
        n_chk++; if (outs() !== 104'h0) begin n_fail++; $display("FAIL reset_hold: outputs %h required 0", outs()); end
        core_req = 1'b0; reset = 1'b0;
        tick();
        n_chk++; if (outs() !== 104'h0) begin n_fail++; $display("FAIL reset_idle: outputs %h required 0", outs()); end
    endtask

    task automatic test_load();
        bit ok; int r0, v0;
        mem[8'hFF] = 32'hAABB_CCDD; ref_mem[8'hFF] = 32'hAABB_CCDD;
        lat = 7; r0 = reqs.size();
        core_xfer(1'b0, 4'hF, 32'h0000_03FC, 32'h0, ok);
        n_chk++; if (!ok || reqs.size() != r0 + 1) begin n_fail++; $display("FAIL load_handshake: ok %0d req_do count %0d required 1", ok, reqs.size() - r0); end
        else begin
            n_chk++; if ({reqs[r0].t, reqs[r0].a} !== {REQ_READ, 32'h3FC}) begin n_fail++; $display("FAIL load_req: type/addr %h required 0_000003fc", {reqs[r0].t, reqs[r0].a}); end
            n_chk++; if (rv_cyc != reqs[r0].c + 8) begin n_fail++; $display("FAIL load_timing: rvalid %0d cycles after req_do required 8", rv_cyc - reqs[r0].c); end
        end
        n_chk++; if (rv_dat !== 32'hAABB_CCDD || rv_err !== 1'b0) begin n_fail++; $display("FAIL load_data: %h err %b required aabbccdd err 0", rv_dat, rv_err); end
        ref_rdata = 32'hAABB_CCDD;
        v0 = n_rv; tick(); tick();
        n_chk++; if (n_rv != v0) begin n_fail++; $display("FAIL load_pulse: extra rvalid %0d required 0", n_rv - v0); end
    endtask

    task automatic test_full_store();
        bit ok; int r0;
        lat = 1; r0 = reqs.size();
        core_xfer(1'b1, 4'hF, 32'h0000_0203, 32'h1234_5678, ok);
        ref_mem[8'h80] = 32'h1234_5678;
        n_chk++; if (!ok || reqs.size() != r0 + 1) begin n_fail++; $display("FAIL fstore_handshake: ok %0d req_do count %0d required 1", ok, reqs.size() - r0); end
        else begin
            n_chk++; if ({reqs[r0].t, reqs[r0].a, reqs[r0].d} !== {REQ_WRITE, 32'h200, 32'h1234_5678}) begin n_fail++;
                $display("FAIL fstore_req: %h required 1_00000200_12345678", {reqs[r0].t, reqs[r0].a, reqs[r0].d}); end
        end
        n_chk++; if (rv_dat !== ref_rdata) begin n_fail++; $display("FAIL fstore_rdata_held: %h required %h", rv_dat, ref_rdata); end
    endtask

    task automatic test_partial_store();
        bit ok; int r0;
        lat = 1; r0 = reqs.size();
        core_xfer(1'b1, 4'b0010, 32'h0000_03FC, 32'h0000_EE00, ok);
        ref_mem[8'hFF] = 32'hAABB_EEDD;
        n_chk++; if (!ok || reqs.size() != r0 + 2) begin n_fail++; $display("FAIL pstore_count: ok %0d req_do count %0d required 2", ok, reqs.size() - r0); end
        else begin
            n_chk++; if ({reqs[r0].t, reqs[r0].a} !== {REQ_READ, 32'h3FC}) begin n_fail++; $display("FAIL pstore_read: %h required 0_000003fc", {reqs[r0].t, reqs[r0].a}); end
            n_chk++; if ({reqs[r0+1].t, reqs[r0+1].a, reqs[r0+1].d} !== {REQ_WRITE, 32'h3FC, 32'hAABB_EEDD}) begin n_fail++;
                $display("FAIL pstore_write: %h required 1_000003fc_aabbeedd", {reqs[r0+1].t, reqs[r0+1].a, reqs[r0+1].d}); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int prev;
        lat = 1;
        core_xfer(1'b0, 4'hF, 32'h0000_0200, 32'h0, ok);
        prev = rv_cyc;
        core_xfer(1'b0, 4'hF, 32'h0000_03FC, 32'h0, ok);
        ref_rdata = ref_mem[8'hFF];
        n_chk++; if (gnt_cyc != prev + 1) begin n_fail++; $display("FAIL b2b_gnt: grant %0d cycles after rvalid required 1", gnt_cyc - prev); end
        n_chk++; if (rv_cyc - gnt_cyc != 3 || rv_dat !== ref_rdata) begin n_fail++;
            $display("FAIL b2b_load: latency %0d data %h required 3 %h", rv_cyc - gnt_cyc, rv_dat, ref_rdata); end
    endtask

    task automatic test_random();
        bit ok; int r0, exp_n, exp_lat, l;
        logic we; logic [3:0] be; logic [31:0] addr, wd; logic [7:0] idx;
        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom_range(0, 1));
            be   = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            addr = 32'($urandom_range(0, 1023));
            wd   = $urandom;
            l    = $urandom_range(1, 4);
            idx  = addr[9:2];
            exp_n = (be == 4'h0) ? 0 : ((!we || be == 4'hF) ? 1 : 2);
            exp_lat = (exp_n == 0) ? 1 : ((exp_n == 2) ? 2 * l + 4 : l + 2);
            if (we) begin
                for (int i = 0; i < 4; i++) if (be[i]) ref_mem[idx][i*8 +: 8] = wd[i*8 +: 8];
            end else if (be != 4'h0) begin
                ref_rdata = ref_mem[idx];
            end
            lat = l; r0 = reqs.size();
            core_xfer(we, be, addr, wd, ok);
            n_chk++; if (!ok || reqs.size() - r0 != exp_n) begin n_fail++;
                $display("FAIL rnd_count[%0d]: ok %0d req_do %0d required %0d", t, ok, reqs.size() - r0, exp_n); end
            n_chk++; if (rv_dat !== ref_rdata || rv_err !== 1'b0 || rv_cyc - gnt_cyc != exp_lat) begin n_fail++;
                $display("FAIL rnd_resp[%0d]: data %h err %b lat %0d required %h 0 %0d", t, rv_dat, rv_err, rv_cyc - gnt_cyc, ref_rdata, exp_lat); end
            if (exp_n > 0 && reqs.size() > r0) begin
                n_chk++; if (reqs[$].a !== {addr[31:2], 2'b00} || reqs[$].t !== (we ? REQ_WRITE : REQ_READ)) begin n_fail++;
                    $display("FAIL rnd_req[%0d]: addr %h type %0d required %h %0d", t, reqs[$].a, reqs[$].t, {addr[31:2], 2'b00}, we); end
                if (we) begin
                    n_chk++; if (reqs[$].d !== ref_mem[idx]) begin n_fail++; $display("FAIL rnd_wdata[%0d]: %h required %h", t, reqs[$].d, ref_mem[idx]); end
                end
            end
        end
    endtask

    task automatic test_flush();
        int r0, g0, v0, f0;
        lat = 5; r0 = reqs.size(); g0 = n_gnt; v0 = n_rv; f0 = n_fd;
        core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 32'h0000_0100;
        for (int i = 0; i < 20 && n_gnt == g0; i++) tick();
        core_req = 1'b0;
        tick(); tick();
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        for (int i = 0; i < 50 && n_rv == v0; i++) tick();
        ref_rdata = ref_mem[8'h40];
        n_chk++; if (n_rv != v0 + 1 || rv_dat !== ref_rdata || n_fd != f0 || reqs.size() != r0 + 1) begin n_fail++;
            $display("FAIL flush_load_first: rv %0d data %h flush_done %0d req_do %0d required 1 %h 0 1", n_rv - v0, rv_dat, n_fd - f0, reqs.size() - r0, ref_rdata); end
        core_req = 1'b1; core_addr = 32'h0000_0104; g0 = n_gnt;
        for (int i = 0; i < 50 && n_fd == f0; i++) tick();
        n_chk++; if (n_fd != f0 + 1 || n_gnt != g0) begin n_fail++; $display("FAIL flush_blocks_gnt: flush_done %0d gnt %0d required 1 0", n_fd - f0, n_gnt - g0); end
        if (reqs.size() > r0 + 1) begin
            n_chk++; if ({reqs[r0+1].t, reqs[r0+1].a} !== {REQ_FLUSH, 32'h0}) begin n_fail++; $display("FAIL flush_req: %h required 2_00000000", {reqs[r0+1].t, reqs[r0+1].a}); end
        end
        for (int i = 0; i < 20 && n_gnt == g0; i++) tick();
        core_req = 1'b0; v0 = n_rv;
        n_chk++; if (gnt_cyc != fd_cyc + 1) begin n_fail++; $display("FAIL flush_then_gnt: grant %0d cycles after flush_done required 1", gnt_cyc - fd_cyc); end
        for (int i = 0; i < 50 && n_rv == v0; i++) tick();
        ref_rdata = ref_mem[8'h41];
        n_chk++; if (rv_dat !== ref_rdata) begin n_fail++; $display("FAIL flush_held_load: %h required %h", rv_dat, ref_rdata); end
    endtask

    task automatic test_flush_held();
        int r0, f0;
        lat = 2; r0 = reqs.size(); f0 = n_fd;
        flush_req = 1'b1;
        for (int i = 0; i < 50 && n_fd < f0 + 2; i++) tick();
        flush_req = 1'b0;
        repeat (5) tick();
        n_chk++; if (n_fd != f0 + 2 || reqs.size() != r0 + 2) begin n_fail++;
            $display("FAIL flush_level: flush_done %0d req_do %0d required 2 2", n_fd - f0, reqs.size() - r0); end
    endtask

    task automatic test_timeout();
        bit ok; int r0, f0;
        lat = -1; r0 = reqs.size();
        core_xfer(1'b0, 4'hF, 32'h0000_03F0, 32'h0, ok);
        n_chk++; if (!ok || rv_err !== 1'b1 || rv_dat !== 32'h0) begin n_fail++; $display("FAIL tmo_resp: ok %0d err %b data %h required 1 1 0", ok, rv_err, rv_dat); end
        if (reqs.size() > r0) begin
            n_chk++; if (rv_cyc - reqs[r0].c != TMO) begin n_fail++; $display("FAIL tmo_cycle: abort %0d cycles after req_do required %0d", rv_cyc - reqs[r0].c, TMO); end
        end
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: %b required 1", err_sticky); end
        lat = TMO; r0 = reqs.size();
        core_xfer(1'b0, 4'hF, 32'h0000_03F4, 32'h0, ok);
        ref_rdata = ref_mem[8'hFD];
        n_chk++; if (!ok || rv_err !== 1'b0 || rv_dat !== ref_rdata || rv_cyc - reqs[r0].c != TMO + 1) begin n_fail++;
            $display("FAIL tmo_done_wins: err %b data %h lat %0d required 0 %h %0d", rv_err, rv_dat, rv_cyc - reqs[r0].c, ref_rdata, TMO + 1); end
        lat = -1; r0 = reqs.size(); f0 = n_fd;
        flush_req = 1'b1;
        for (int i = 0; i < 60 && n_fd == f0; i++) begin tick(); flush_req = 1'b0; end
        if (reqs.size() > r0) begin
            n_chk++; if (n_fd != f0 + 1 || fd_cyc - reqs[r0].c != TMO) begin n_fail++;
                $display("FAIL tmo_flush: flush_done %0d after %0d cycles required 1 after %0d", n_fd - f0, fd_cyc - reqs[r0].c, TMO); end
        end
        n_chk++; if (err_sticky !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky_after: %b required 1", err_sticky); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int r0, g0, v0, f0;
        lat = 5; g0 = n_gnt;
        core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; core_addr = 32'h0000_0010;
        for (int i = 0; i < 20 && n_gnt == g0; i++) tick();
        core_req = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        n_chk++; if (outs() !== 104'h0) begin n_fail++; $display("FAIL rst_wait_outs: %h required 0", outs()); end
        r0 = reqs.size(); v0 = n_rv; f0 = n_fd;
        repeat (6) tick();
        n_chk++; if (n_rv != v0 || reqs.size() != r0 || n_fd != f0) begin n_fail++;
            $display("FAIL rst_late_done: rv %0d req_do %0d flush_done %0d required 0 0 0", n_rv - v0, reqs.size() - r0, n_fd - f0); end
        core_xfer(1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, ok);
        n_chk++; if (!ok || rv_cyc - gnt_cyc != 1 || reqs.size() != r0 || rv_err !== 1'b0 || rv_dat !== 32'h0) begin n_fail++;
            $display("FAIL rst_be0_store: ok %0d lat %0d req_do %0d err %b data %h required 1 1 0 0 0", ok, rv_cyc - gnt_cyc, reqs.size() - r0, rv_err, rv_dat); end
    endtask

    initial begin
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_be = 4'h0; core_addr = '0; core_wdata = '0;
        flush_req = 1'b0; cif.req_done = 1'b0; cif.O_data = '0; lat = 1; ref_rdata = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_back_to_back();
        test_random();
        test_flush();
        test_flush_held();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
